// File: rtl/run_ctrl_pkg.sv
// Shared types for run_ctrl: run-state encoding, speed code and the speed-to-divisor shifts.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } run_state_t;

  typedef logic [1:0] speed_t;

  // Tick period is N >> shift, so speeds 0..3 divide N by 1, 2, 4, 16.
  localparam logic [2:0] SPEED_SHIFT [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

  function automatic logic [31:0] tick_period(input logic [31:0] n, input speed_t s);
    return n >> SPEED_SHIFT[s];
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a debouncer; the output follows the input only after
// DB_CYCLES consecutive cycles of disagreement, so shorter glitches never propagate.
module sw_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/run_ctrl.sv
// CPU run/pause/step controller from debounced panel switches; cpu_en is a registered one-cycle enable.
// RUN_CTRL_STEP_EN adds the single-step button and STEP state; without it btn_step is ignored.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int N         = 10_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          sw,
  input  logic                 btn_step,
  output logic                 cpu_en,
  output logic                 cpu_rst,
  output logic [1:0]           speed,
  output logic [1:0]           run_state,
  output logic [2:0]           display_op,
  output logic [ADDR_BITS-3:0] ram_display_addr
);

  localparam int DBW   = ADDR_BITS + 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [DBW-1:0]       w_db;
  logic                 w_step_db;
  logic                 w_go;
  logic                 w_hold;
  logic                 w_spd_rise;
  logic                 w_step_rise;
  logic                 w_term;
  logic                 w_unused;
  logic [31:0]          w_period;

  run_state_t           r_state;
  speed_t               r_speed;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_cpu_en;
  logic                 r_cpu_rst;
  logic                 r_spd_q;
  logic                 r_step_q;
  logic [2:0]           r_op;
  logic [ADDR_BITS-3:0] r_addr;

  for (genvar gi = 0; gi < DBW; gi++) begin : g_sw_db
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .i_raw (sw[gi]),
      .o_db  (w_db[gi])
    );
  end

`ifdef RUN_CTRL_STEP_EN
  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (btn_step),
    .o_db  (w_step_db)
  );
`else
  assign w_step_db = 1'b0;
`endif

  assign w_unused    = &{1'b0, btn_step, sw};
  assign w_go        = w_db[0];
  assign w_hold      = w_db[1];
  assign w_spd_rise  = w_db[2] & ~r_spd_q;
  assign w_step_rise = w_step_db & ~r_step_q;
  assign w_period    = tick_period(32'(N), r_speed);
  assign w_term      = (r_cnt == CNT_W'(w_period - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HOLD;
      r_cpu_rst <= 1'b1;
      r_cpu_en  <= 1'b0;
      r_speed   <= '0;
      r_cnt     <= '0;
      r_spd_q   <= 1'b0;
      r_step_q  <= 1'b0;
    end else begin
      r_spd_q  <= w_db[2];
      r_step_q <= w_step_db;
      r_cpu_en <= 1'b0;
      if (w_spd_rise) r_speed <= r_speed + 2'd1;
      if (w_hold) begin
        r_state   <= ST_HOLD;
        r_cpu_rst <= 1'b1;
        r_cnt     <= '0;
      end else begin
        r_cpu_rst <= 1'b0;
        case (r_state)
          ST_HOLD: begin
            r_cnt   <= '0;
            r_state <= w_go ? ST_RUN : ST_PAUSE;
          end
          ST_PAUSE: begin
            if (w_go) begin
              r_state <= ST_RUN;
            end else if (w_step_rise) begin
              r_state  <= ST_STEP;
              r_cpu_en <= 1'b1;
            end
          end
          // Losing go in the terminal cycle leaves the count parked and drops that tick.
          ST_RUN: begin
            if (!w_go) begin
              r_state <= ST_PAUSE;
            end else if (w_term && !w_spd_rise) begin
              r_cnt    <= '0;
              r_cpu_en <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STEP: r_state <= ST_PAUSE;
          default: r_state <= ST_HOLD;
        endcase
        // A speed change restarts the period and overrides any count update above.
        if (w_spd_rise) r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_addr <= '0;
    end else begin
      r_op   <= w_db[5:3];
      r_addr <= w_db[ADDR_BITS+3:6];
    end
  end

  assign cpu_en           = r_cpu_en;
  assign cpu_rst          = r_cpu_rst;
  assign speed            = r_speed;
  assign run_state        = r_state;
  assign display_op       = r_op;
  assign ram_display_addr = r_addr;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl with N=16, DB_CYCLES=4: vector table, directed timing sequences and a
// randomized run compared every cycle against a behavioural model of the control rules.
module tb_run_ctrl;

  localparam int TN  = 16;
  localparam int TDB = 4;
  localparam int TAB = 12;
`ifdef RUN_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  localparam int S_HOLD = 0, S_PAUSE = 1, S_RUN = 2, S_STEP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   sw;
  logic          btn_step;
  logic          cpu_en, cpu_rst;
  logic [1:0]    speed, run_state;
  logic [2:0]    display_op;
  logic [TAB-3:0] ram_display_addr;

  run_ctrl #(.N(TN), .DB_CYCLES(TDB), .ADDR_BITS(TAB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sw               (sw),
    .btn_step         (btn_step),
    .cpu_en           (cpu_en),
    .cpu_rst          (cpu_rst),
    .speed            (speed),
    .run_state        (run_state),
    .display_op       (display_op),
    .ram_display_addr (ram_display_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int maxc, output int n);
    n = 0;
    while (int'(run_state) != s && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_en(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_en && n < maxc);
  endtask

  // Behavioural model: signals reach the debouncer two edges late, a debounced bit flips once it
  // has disagreed for TDB cycles, and a tick fires once TN/divisor RUN cycles have accumulated.
  function automatic int speed_div(input int s);
    case (s)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 16;
    endcase
  endfunction

  logic [16:0] m_s1, m_s2, m_db;
  int          m_run [17];
  int          m_state, m_en, m_rst, m_speed, m_acc, m_op, m_addr, m_p;
  bit          m_pspd, m_pstep, m_go, m_hold, m_srise, m_brise;
  bit          m_chk = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int b = 0; b < 17; b++) m_run[b] = 0;
      m_state = S_HOLD; m_en = 0; m_rst = 1; m_speed = 0; m_acc = 0;
      m_op = 0; m_addr = 0; m_pspd = 1'b0; m_pstep = 1'b0;
    end else begin
      m_go    = m_db[0];
      m_hold  = m_db[1];
      m_srise = m_db[2] && !m_pspd;
      m_brise = STEP_EN && m_db[16] && !m_pstep;
      m_p     = TN / speed_div(m_speed);
      m_en    = 0;
      m_op    = int'(m_db[5:3]);
      m_addr  = int'(m_db[15:6]);
      if (m_hold) begin
        m_state = S_HOLD;
        m_acc   = 0;
      end else begin
        case (m_state)
          S_HOLD:  m_state = m_go ? S_RUN : S_PAUSE;
          S_PAUSE: if (m_go) m_state = S_RUN;
                   else if (m_brise) begin m_state = S_STEP; m_en = 1; end
          S_RUN:   if (!m_go) m_state = S_PAUSE;
                   else if (!m_srise) begin
                     m_acc++;
                     if (m_acc == m_p) begin m_acc = 0; m_en = 1; end
                   end
          default: m_state = S_PAUSE;
        endcase
      end
      if (m_srise) begin m_speed = (m_speed + 1) % 4; m_acc = 0; end
      m_rst   = (m_state == S_HOLD) ? 1 : 0;
      m_pspd  = m_db[2];
      m_pstep = m_db[16];
      for (int b = 0; b < 17; b++) begin
        if (m_s2[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == TDB) begin m_db[b] = m_s2[b]; m_run[b] = 0; end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_step, sw};
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_chk) begin
      chk("model_cpu_en",    int'(cpu_en),           m_en);
      chk("model_cpu_rst",   int'(cpu_rst),          m_rst);
      chk("model_speed",     int'(speed),            m_speed);
      chk("model_run_state", int'(run_state),        m_state);
      chk("model_disp_op",   int'(display_op),       m_op);
      chk("model_disp_addr", int'(ram_display_addr), m_addr);
    end
  end

  typedef struct {
    logic [15:0] sw;
    int st; int rs; int spd; int op; int addr;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  int          n, cnt_en, cnt_step;
  int          exp_spd [4];
  int          exp_per [4];
  logic [15:0] rnd_sw;

  initial begin
    tbl[0] = '{16'h0002, S_HOLD,  1, 0, 0, 0};
    tbl[1] = '{16'h0000, S_PAUSE, 0, 0, 0, 0};
    tbl[2] = '{16'h0001, S_RUN,   0, 0, 0, 0};
    tbl[3] = '{16'h0005, S_RUN,   0, 1, 0, 0};
    tbl[4] = '{16'h0001, S_RUN,   0, 1, 0, 0};
    tbl[5] = '{16'h0004, S_PAUSE, 0, 2, 0, 0};
    tbl[6] = '{16'h0D59, S_RUN,   0, 2, 3, 'h35};
    tbl[7] = '{16'hFFFF, S_HOLD,  1, 3, 7, 'h3FF};
    tbl[8] = '{16'h0000, S_PAUSE, 0, 3, 0, 0};
    tbl[9] = '{16'h0004, S_PAUSE, 0, 0, 0, 0};
    exp_spd = '{1, 2, 3, 0};
    exp_per = '{8, 4, 1, 16};

    rst_n = 1'b0; sw = 16'h0000; btn_step = 1'b0;
    repeat (3) tick();
    chk("rst_run_state", int'(run_state), S_HOLD);
    chk("rst_cpu_rst", int'(cpu_rst), 1);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_disp_op", int'(display_op), 0);
    chk("rst_disp_addr", int'(ram_display_addr), 0);
    m_chk = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      sw = tbl[i].sw;
      repeat (12) tick();
      chk($sformatf("tbl%0d_state", i), int'(run_state), tbl[i].st);
      chk($sformatf("tbl%0d_cpu_rst", i), int'(cpu_rst), tbl[i].rs);
      chk($sformatf("tbl%0d_speed", i), int'(speed), tbl[i].spd);
      chk($sformatf("tbl%0d_op", i), int'(display_op), tbl[i].op);
      chk($sformatf("tbl%0d_addr", i), int'(ram_display_addr), tbl[i].addr);
    end

    // Reset release with go held: HOLD, then RUN after sync+debounce, then 16-cycle ticks.
    rst_n = 1'b0; sw = 16'h0001;
    repeat (3) tick();
    chk("go_rst_state", int'(run_state), S_HOLD);
    chk("go_rst_cpu_rst", int'(cpu_rst), 1);
    rst_n = 1'b1;
    wait_state(S_RUN, 30, n);
    chk("run_entry_cycles", n, 7);
    wait_en(40, n);
    chk("first_tick_cycles", n, 16);
    wait_en(40, n);
    chk("tick_period_s0", n, 16);

    for (int k = 0; k < 4; k++) begin
      sw = 16'h0005; repeat (8) tick();
      sw = 16'h0001; repeat (8) tick();
      chk($sformatf("pulse%0d_speed", k), int'(speed), exp_spd[k]);
      wait_en(40, n);
      wait_en(40, n);
      chk($sformatf("pulse%0d_period", k), n, exp_per[k]);
    end

    // Drop go so the debounced fall lands while the count is 10, idle, then resume.
    wait_en(40, n);
    repeat (4) tick();
    sw = 16'h0000;
    cnt_en = 0;
    repeat (56) begin tick(); if (cpu_en) cnt_en++; end
    chk("pause_no_cpu_en", cnt_en, 0);
    chk("pause_state", int'(run_state), S_PAUSE);
    sw = 16'h0001;
    wait_state(S_RUN, 30, n);
    chk("resume_entry_cycles", n, 7);
    wait_en(40, n);
    chk("resume_tick_cycles", n, 6);

    sw = 16'h0000;
    repeat (10) tick();
    chk("step_pre_state", int'(run_state), S_PAUSE);
    btn_step = 1'b1; repeat (2) tick(); btn_step = 1'b0;
    cnt_en = 0; cnt_step = 0;
    repeat (20) begin tick(); if (cpu_en) cnt_en++; if (run_state == 2'd3) cnt_step++; end
    chk("glitch_cpu_en", cnt_en, 0);
    chk("glitch_step_state", cnt_step, 0);
    btn_step = 1'b1;
    cnt_en = 0; cnt_step = 0;
    repeat (10) begin tick(); if (cpu_en) cnt_en++; if (run_state == 2'd3) cnt_step++; end
    btn_step = 1'b0;
    repeat (20) begin tick(); if (cpu_en) cnt_en++; if (run_state == 2'd3) cnt_step++; end
    chk("step_cpu_en_count", cnt_en, STEP_EN ? 1 : 0);
    chk("step_state_count", cnt_step, STEP_EN ? 1 : 0);
    chk("step_post_state", int'(run_state), S_PAUSE);

    sw = 16'h0001;
    wait_state(S_RUN, 30, n);
    repeat (5) tick();
    sw = 16'h0003;
    repeat (6) tick();
    chk("hold_cpu_rst_early", int'(cpu_rst), 0);
    tick();
    chk("hold_cpu_rst", int'(cpu_rst), 1);
    chk("hold_state", int'(run_state), S_HOLD);
    cnt_en = 0;
    repeat (20) begin tick(); if (cpu_en) cnt_en++; end
    chk("hold_no_cpu_en", cnt_en, 0);
    sw = 16'h0001;
    wait_state(S_RUN, 30, n);
    chk("unhold_entry_cycles", n, 7);
    wait_en(40, n);
    chk("unhold_first_tick", n, 16);

    sw = 16'h0D58;
    repeat (6) tick();
    chk("disp_op_early", int'(display_op), 0);
    tick();
    chk("disp_op", int'(display_op), 3);
    chk("disp_addr", int'(ram_display_addr), 'h35);

    for (int seg = 0; seg < 250; seg++) begin
      rnd_sw    = 16'($urandom);
      rnd_sw[0] = ($urandom_range(0, 3) != 0);
      rnd_sw[1] = ($urandom_range(0, 9) == 0);
      sw        = rnd_sw;
      btn_step  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 24)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
